demux_capture: RTL and testbench



---
 rtl/demux_capture_if.sv | 16 +
 rtl/demux_capture.sv | 56 +++++
 tb/tb_demux_capture.sv | 132 +++++++++++++
 3 files changed

// File: rtl/demux_capture_if.sv
// demux_capture_if: serial-in / parallel-out handshake bundle for demux_capture
interface demux_capture_if #(parameter int NUM_OUT = 8, parameter int SEL_W = 3);
  logic               in_valid;
  logic               in_data;
  logic               in_ready;
  logic               sel_mode;
  logic [SEL_W-1:0]   select;
  logic [NUM_OUT-1:0] out_word;
  logic               out_valid;
  logic               out_ready;
  logic               drop;
  modport master(output in_valid, in_data, sel_mode, select, out_ready,
                 input in_ready, out_word, out_valid, drop);
  modport slave(input in_valid, in_data, sel_mode, select, out_ready,
                output in_ready, out_word, out_valid, drop);
endinterface

// File: rtl/demux_capture.sv
// demux_capture: 1-to-NUM_OUT serial deserializer with auto or external lane select
module demux_capture #(
  parameter int NUM_OUT = 8,
  parameter int SEL_W = 3
) (
  input logic clk,
  input logic rst,
  demux_capture_if.slave bus
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [SEL_W-1:0] ptr, idx;
  logic [NUM_OUT-1:0] mask, mask_nx;
  logic mode_q, acc, chg, done;
  assign bus.in_ready = state == FILL;
  assign acc = bus.in_valid & bus.in_ready;
  assign idx = mode_q ? bus.select : ptr;
  assign mask_nx = mask | (NUM_OUT'(1) << idx);
  assign chg = state == FILL && bus.sel_mode != mode_q;
  assign done = acc && (mode_q ? &mask_nx : ptr == SEL_W'(NUM_OUT - 1));
  // a mode switch discards the partial frame, including a coincident accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      ptr <= '0;
      mask <= '0;
      mode_q <= 1'b0;
      bus.out_word <= '0;
      bus.out_valid <= 1'b0;
      bus.drop <= 1'b0;
    end else begin
      bus.drop <= 1'b0;
      if (state == FILL) begin
        mode_q <= bus.sel_mode;
        if (acc) bus.out_word[idx] <= bus.in_data;
        if (chg) begin
          mask <= '0;
          ptr <= '0;
          bus.drop <= |mask;
        end else if (acc) begin
          mask <= mask_nx;
          if (!mode_q) ptr <= ptr + 1'b1;
          if (done) begin
            state <= HOLD;
            bus.out_valid <= 1'b1;
          end
        end
      end else if (bus.out_ready) begin
        state <= FILL;
        bus.out_valid <= 1'b0;
        mask <= '0;
        ptr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_demux_capture.sv
// tb_demux_capture: directed self-checking bench for demux_capture
module tb_demux_capture;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [7:0] w;
  always #5 clk = ~clk;
  demux_capture_if #(.NUM_OUT(8), .SEL_W(3)) bus();
  demux_capture #(.NUM_OUT(8), .SEL_W(3)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic d, input logic [2:0] s);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.select = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 1'b0;
    bus.sel_mode = 1'b0;
    bus.select = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_word", bus.out_word, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_drop", bus.drop, 0);
    chk("rst_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    // auto frame, consumer always ready
    for (int i = 0; i < 8; i++) send(i % 2 == 0, 3'd0);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_word", bus.out_word, 8'h55);
    chk("t1_inready", bus.in_ready, 0);
    @(negedge clk);
    chk("t1_valid_off", bus.out_valid, 0);
    chk("t1_inready_on", bus.in_ready, 1);
    // consumer stalls for 5 cycles; producer keeps driving
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(i % 2 == 0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", bus.out_valid, 1);
      chk("t2_hold_word", bus.out_word, 8'h55);
      chk("t2_hold_inready", bus.in_ready, 0);
      bus.in_valid = 1'b1;
      bus.in_data = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t2_release", bus.out_valid, 0);
    for (int i = 0; i < 8; i++) send(i < 4, 3'd0);
    chk("t2_next_valid", bus.out_valid, 1);
    chk("t2_next_word", bus.out_word, 8'h0F);
    @(negedge clk);
    // external select, descending lanes
    bus.sel_mode = 1'b1;
    @(negedge clk);
    chk("t3_nodrop", bus.drop, 0);
    for (int i = 0; i < 8; i++) send(i < 4, 3'(7 - i));
    chk("t3_valid", bus.out_valid, 1);
    chk("t3_word", bus.out_word, 8'hF0);
    @(negedge clk);
    // lane 3 written twice, then remaining lanes
    send(1'b0, 3'd3);
    send(1'b1, 3'd3);
    w = 8'h5C;
    for (int i = 7; i >= 1; i--) if (i != 3) send(w[i], 3'(i));
    chk("t3_partial", bus.out_valid, 0);
    send(w[0], 3'd0);
    chk("t3b_valid", bus.out_valid, 1);
    chk("t3b_word", bus.out_word, 8'h5C);
    @(negedge clk);
    // mode flip mid-frame
    bus.sel_mode = 1'b0;
    @(negedge clk);
    chk("t4_idle_drop", bus.drop, 0);
    for (int i = 0; i < 3; i++) send(1'b1, 3'd0);
    bus.sel_mode = 1'b1;
    @(negedge clk);
    chk("t4_drop", bus.drop, 1);
    @(negedge clk);
    chk("t4_drop_pulse", bus.drop, 0);
    w = 8'h3C;
    for (int i = 7; i >= 1; i--) send(w[i], 3'(i));
    chk("t4_no_stale", bus.out_valid, 0);
    send(w[0], 3'd0);
    chk("t4_valid", bus.out_valid, 1);
    chk("t4_word", bus.out_word, 8'h3C);
    @(negedge clk);
    // async reset mid-frame
    bus.sel_mode = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) send(1'b1, 3'd0);
    #2 rst = 1'b1;
    #1;
    chk("t5_word", bus.out_word, 0);
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_ptr", dut.ptr, 0);
    chk("t5_drop", bus.drop, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    w = 8'hA5;
    for (int i = 0; i < 8; i++) send(w[i], 3'd0);
    chk("t5_valid2", bus.out_valid, 1);
    chk("t5_word2", bus.out_word, 8'hA5);
    @(negedge clk);
    // in_valid every other cycle
    w = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      send(w[i], 3'd0);
      if (i < 7) @(negedge clk);
      if (i == 6) chk("t6_partial", bus.out_valid, 0);
    end
    chk("t6_valid", bus.out_valid, 1);
    chk("t6_word", bus.out_word, 8'hC3);
    @(negedge clk);
    chk("t6_done", bus.out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
